// File: rtl/vx_axi_wr_sched_pkg.sv
// Shared AXI constants, AW request record and AxSIZE helper for the write scheduler.
package vx_axi_wr_sched_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Widest address / id the AW record can carry; narrower ports are zero-extended.
  localparam int AW_ADDR_MAX = 64;
  localparam int AW_ID_MAX   = 32;

  typedef struct packed {
    logic [AW_ADDR_MAX-1:0] addr;
    logic [AW_ID_MAX-1:0]   id;
    logic [7:0]             len;
  } aw_req_t;

  function automatic logic [2:0] axi_size_enc(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/vx_axi_wr_order_fifo.sv
// Small sync FIFO holding the master index of each granted AW, in grant order.
module vx_axi_wr_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]                r_wr_ptr;
  logic [PTR_W:0]                r_rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]   r_mem;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vx_axi_wr_sched.sv
// Shares one AXI write slave among NUM_INPUTS masters: round-robin AW, W in grant order, B by AWID select.
// Optional stall counters enabled by defining VX_AXI_WR_SCHED_PERF_EN.
module vx_axi_wr_sched
  import vx_axi_wr_sched_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int TID_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  parameter int ORDER_DEPTH = 4,
  localparam int SEL_BITS   = $clog2(NUM_INPUTS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_INPUTS-1:0]                    s_awvalid,
  output logic [NUM_INPUTS-1:0]                    s_awready,
  input  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0]    s_awaddr,
  input  logic [NUM_INPUTS-1:0][TID_WIDTH-1:0]     s_awid,
  input  logic [NUM_INPUTS-1:0][7:0]               s_awlen,
  input  logic [NUM_INPUTS-1:0]                    s_wvalid,
  output logic [NUM_INPUTS-1:0]                    s_wready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    s_wdata,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH/8-1:0]  s_wstrb,
  input  logic [NUM_INPUTS-1:0]                    s_wlast,
  output logic [NUM_INPUTS-1:0]                    s_bvalid,
  input  logic [NUM_INPUTS-1:0]                    s_bready,
  output logic [TID_WIDTH-1:0]                     s_bid,
  output logic [1:0]                               s_bresp,
  output logic                                     m_awvalid,
  input  logic                                     m_awready,
  output logic [ADDR_WIDTH-1:0]                    m_awaddr,
  output logic [TID_WIDTH+SEL_BITS-1:0]            m_awid,
  output logic [7:0]                               m_awlen,
  output logic [2:0]                               m_awsize,
  output logic [1:0]                               m_awburst,
  output logic                                     m_wvalid,
  input  logic                                     m_wready,
  output logic [DATA_WIDTH-1:0]                    m_wdata,
  output logic [DATA_WIDTH/8-1:0]                  m_wstrb,
  output logic                                     m_wlast,
  input  logic                                     m_bvalid,
  output logic                                     m_bready,
  input  logic [TID_WIDTH+SEL_BITS-1:0]            m_bid,
  input  logic [1:0]                               m_bresp,
  output logic                                     idle,
  output logic                                     err
`ifdef VX_AXI_WR_SCHED_PERF_EN
  ,
  output logic [NUM_INPUTS-1:0][31:0]              perf_aw_stall,
  output logic [31:0]                              perf_w_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

  logic [NUM_INPUTS-1:0]             w_elig;
  logic                              w_found;
  logic                              w_grant;
  logic [SEL_BITS-1:0]               w_winner;
  logic [SEL_BITS-1:0]               r_rr;
  logic [SEL_BITS-1:0]               r_sel;
  logic                              r_awvalid;
  aw_req_t                           r_aw;
  logic                              w_unused_aw;
  logic                              w_fifo_full;
  logic                              w_fifo_empty;
  logic                              w_pop;
  logic [SEL_BITS-1:0]               w_head;
  logic [NUM_INPUTS-1:0][CNT_W-1:0]  r_pend;
  logic [NUM_INPUTS-1:0]             w_inc;
  logic [NUM_INPUTS-1:0]             w_dec;
  logic                              w_pend_zero;
  logic [SEL_BITS-1:0]               w_bsel;
  logic                              w_bsel_ok;
  logic                              w_b_bad;
  logic                              w_b_hs;
  logic                              r_err;

  // AW arbitration: first eligible master at or after the round-robin pointer
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      w_elig[i] = s_awvalid[i] && (r_pend[i] < PEND_MAX) && !w_fifo_full;
  end

  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!w_found && w_elig[idx]) begin
        w_found  = 1'b1;
        w_winner = SEL_BITS'(idx);
      end
    end
  end

  assign w_grant = reset && w_found && (!r_awvalid || m_awready);

  always_comb begin
    s_awready = '0;
    if (w_grant) s_awready[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_awvalid <= 1'b0;
      r_aw      <= '0;
      r_sel     <= '0;
      r_rr      <= '0;
    end else if (w_grant) begin
      r_awvalid <= 1'b1;
      r_sel     <= w_winner;
      r_aw.addr <= AW_ADDR_MAX'(s_awaddr[w_winner]);
      r_aw.id   <= AW_ID_MAX'(s_awid[w_winner]);
      r_aw.len  <= s_awlen[w_winner];
      r_rr      <= (w_winner == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : w_winner + 1'b1;
    end else if (m_awready) begin
      r_awvalid <= 1'b0;
    end
  end

  assign m_awvalid   = r_awvalid;
  assign m_awaddr    = r_aw.addr[ADDR_WIDTH-1:0];
  assign m_awid      = {r_sel, r_aw.id[TID_WIDTH-1:0]};
  assign m_awlen     = r_aw.len;
  assign m_awsize    = axi_size_enc(DATA_WIDTH);
  assign m_awburst   = AXI_BURST_INCR;
  assign w_unused_aw = ^r_aw;

  vx_axi_wr_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (SEL_BITS)
  ) u_order_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_grant),
    .i_din   (w_winner),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // W steering: only the master at the FIFO head may move data
  assign m_wvalid = !w_fifo_empty && s_wvalid[w_head];
  assign m_wdata  = s_wdata[w_head];
  assign m_wstrb  = s_wstrb[w_head];
  assign m_wlast  = s_wlast[w_head];
  assign w_pop    = m_wvalid && m_wready && s_wlast[w_head];

  always_comb begin
    s_wready = '0;
    if (!w_fifo_empty) s_wready[w_head] = m_wready;
  end

  assign w_bsel  = m_bid[TID_WIDTH +: SEL_BITS];
  assign s_bid   = m_bid[TID_WIDTH-1:0];
  assign s_bresp = m_bresp;

  generate
    if ((1 << SEL_BITS) == NUM_INPUTS) begin : g_bsel_all
      assign w_bsel_ok = 1'b1;
    end else begin : g_bsel_chk
      assign w_bsel_ok = (w_bsel < SEL_BITS'(NUM_INPUTS));
    end
  endgenerate

  // Out-of-range selects are sunk so a stray response cannot hang the slave
  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b0;
    w_b_bad  = 1'b0;
    if (reset) begin
      if (w_bsel_ok) begin
        s_bvalid[w_bsel] = m_bvalid;
        m_bready         = s_bready[w_bsel];
        w_b_bad          = (r_pend[w_bsel] == '0);
      end else begin
        m_bready = 1'b1;
        w_b_bad  = 1'b1;
      end
    end
  end

  assign w_b_hs = m_bvalid && m_bready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_inc[i] = w_grant && (w_winner == SEL_BITS'(i));
      w_dec[i] = w_b_hs && w_bsel_ok && (w_bsel == SEL_BITS'(i)) && (r_pend[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_inc[i] && !w_dec[i])      r_pend[i] <= r_pend[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_pend[i] <= r_pend[i] - 1'b1;
      end
      if (w_b_hs && w_b_bad) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_pend_zero = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (r_pend[i] != '0) w_pend_zero = 1'b0;
  end

  assign idle = w_fifo_empty && !r_awvalid && w_pend_zero;
  assign err  = r_err;

`ifdef VX_AXI_WR_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_aw_stall <= '0;
      perf_w_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++)
        if (s_awvalid[i] && !s_awready[i]) perf_aw_stall[i] <= perf_aw_stall[i] + 32'd1;
      if (m_wvalid && !m_wready) perf_w_stall <= perf_w_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_axi_wr_sched.sv
// Directed bench for vx_axi_wr_sched: reset, fairness, W ordering, pending limit, full FIFO, B routing, bad B.
module tb_vx_axi_wr_sched;
  import vx_axi_wr_sched_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [1:0]            s_awvalid, s_awready;
  logic [1:0][31:0]      s_awaddr;
  logic [1:0][7:0]       s_awid;
  logic [1:0][7:0]       s_awlen;
  logic [1:0]            s_wvalid, s_wready;
  logic [1:0][31:0]      s_wdata;
  logic [1:0][3:0]       s_wstrb;
  logic [1:0]            s_wlast;
  logic [1:0]            s_bvalid, s_bready;
  logic [7:0]            s_bid;
  logic [1:0]            s_bresp;
  logic                  m_awvalid, m_awready;
  logic [31:0]           m_awaddr;
  logic [8:0]            m_awid;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_wvalid, m_wready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_wlast;
  logic                  m_bvalid, m_bready;
  logic [8:0]            m_bid;
  logic [1:0]            m_bresp;
  logic                  idle, err;
`ifdef VX_AXI_WR_SCHED_PERF_EN
  logic [1:0][31:0]      perf_aw_stall;
  logic [31:0]           perf_w_stall;
`endif

  int n_vec;
  int n_err;

  vx_axi_wr_sched #(
    .NUM_INPUTS  (2),
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .TID_WIDTH   (8),
    .MAX_PENDING (4),
    .ORDER_DEPTH (4)
  ) dut (
    .clk (clk), .reset (reset),
    .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr (s_awaddr),
    .s_awid (s_awid), .s_awlen (s_awlen),
    .s_wvalid (s_wvalid), .s_wready (s_wready), .s_wdata (s_wdata),
    .s_wstrb (s_wstrb), .s_wlast (s_wlast),
    .s_bvalid (s_bvalid), .s_bready (s_bready), .s_bid (s_bid), .s_bresp (s_bresp),
    .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
    .m_awid (m_awid), .m_awlen (m_awlen), .m_awsize (m_awsize), .m_awburst (m_awburst),
    .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata),
    .m_wstrb (m_wstrb), .m_wlast (m_wlast),
    .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bid (m_bid), .m_bresp (m_bresp),
    .idle (idle), .err (err)
`ifdef VX_AXI_WR_SCHED_PERF_EN
    , .perf_aw_stall (perf_aw_stall), .perf_w_stall (perf_w_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One burst from master m at the W head; the other master must see s_wready low
  task automatic w_burst(input int m, input int nb, input logic [31:0] base);
    for (int b = 0; b < nb; b++) begin
      s_wdata[m] = base + 32'(b);
      s_wlast[m] = (b == nb - 1);
      #1;
      chk("w_ready", s_wready, (m == 0) ? 2'b01 : 2'b10);
      chk("w_data",  m_wdata, base + 32'(b));
      chk("w_last",  m_wlast, (b == nb - 1));
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    s_awvalid = 2'b11;
    s_awaddr[0] = 32'h1000; s_awaddr[1] = 32'h2000;
    s_awid[0] = 8'hA0;      s_awid[1] = 8'hB1;
    s_awlen[0] = 8'd1;      s_awlen[1] = 8'd3;
    s_wvalid = 2'b00;
    s_wdata = '0;
    s_wstrb[0] = 4'hF;      s_wstrb[1] = 4'h3;
    s_wlast = 2'b00;
    s_bready = 2'b11;
    m_awready = 1'b1;
    m_wready = 1'b0;
    m_bvalid = 1'b0;
    m_bid = '0;
    m_bresp = AXI_RESP_OKAY;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_awready", s_awready, 2'b00);
    chk("rst_idle",    idle, 1'b1);
    chk("rst_err",     err, 1'b0);
    chk("rst_wvalid",  m_wvalid, 1'b0);
    chk("rst_bready",  m_bready, 1'b0);
    s_bready = 2'b00;
    reset = 1'b1;
    #1;

    // fairness: 0,1,0,1 then the order FIFO is full
    for (int k = 0; k < 4; k++) begin
      chk("fair_ready", s_awready, (k % 2 == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #2;
      chk("fair_awvalid", m_awvalid, 1'b1);
      chk("fair_awid",    m_awid, (k % 2 == 1) ? 9'h1B1 : 9'h0A0);
      chk("fair_awaddr",  m_awaddr, (k % 2 == 1) ? 32'h2000 : 32'h1000);
      chk("fair_awlen",   m_awlen, (k % 2 == 1) ? 8'd3 : 8'd1);
    end
    chk("awsize",     m_awsize, 3'd2);
    chk("awburst",    m_awburst, 2'b01);
    chk("full_block", s_awready, 2'b00);
    chk("busy_idle",  idle, 1'b0);
    @(posedge clk); #2;
    chk("aw_drain", m_awvalid, 1'b0);

    // head is M0 (2 beats); M1 also drives W and must stall
    s_wvalid = 2'b11;
    s_wdata[0] = 32'h11111111;
    s_wdata[1] = 32'h000000B0;
    m_wready = 1'b1;
    #1;
    chk("w0_valid", m_wvalid, 1'b1);
    chk("w0_ready", s_wready, 2'b01);
    chk("w0_data",  m_wdata, 32'h11111111);
    chk("w0_strb",  m_wstrb, 4'hF);
    @(posedge clk); #2;
    s_wdata[0] = 32'h22222222;
    s_wlast[0] = 1'b1;
    #1;
    chk("w0_last",         m_wlast, 1'b1);
    chk("full_pop_block",  s_awready, 2'b00);
    @(posedge clk); #2;
    s_awvalid = 2'b00;
    s_wdata[0] = 32'h33333333;
    s_wlast[0] = 1'b0;
    w_burst(1, 4, 32'h000000B0);
    w_burst(0, 2, 32'h00000033);
    w_burst(1, 4, 32'h000000C0);
    s_wvalid = 2'b00;
    #1;
    chk("w_empty",     m_wvalid, 1'b0);
    chk("pend_nonidle", idle, 1'b0);

    // B routing: two responses per master
    m_bvalid = 1'b1;
    m_bid = 9'h0A0;
    s_bready = 2'b00;
    #1;
    chk("b0_valid", s_bvalid, 2'b01);
    chk("b0_bp",    m_bready, 1'b0);
    chk("b0_id",    s_bid, 8'hA0);
    @(posedge clk); #2;
    s_bready = 2'b01;
    #1;
    chk("b0_ready", m_bready, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    m_bid = 9'h1B1;
    m_bresp = AXI_RESP_SLVERR;
    s_bready = 2'b10;
    #1;
    chk("b1_valid", s_bvalid, 2'b10);
    chk("b1_resp",  s_bresp, 2'b10);
    chk("b1_id",    s_bid, 8'hB1);
    @(posedge clk);
    @(posedge clk); #2;
    m_bvalid = 1'b0;
    m_bresp = AXI_RESP_OKAY;
    #1;
    chk("b_idle", idle, 1'b1);
    chk("b_err",  err, 1'b0);

    // pending limit: M0 single-beat bursts drain W, so only pend_cnt limits it
    s_awlen[0] = 8'd0;
    s_awlen[1] = 8'd0;
    s_wvalid = 2'b01;
    s_wlast = 2'b01;
    s_awvalid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pend_ready", s_awready, 2'b01);
      @(posedge clk); #2;
    end
    s_awvalid = 2'b11;
    #1;
    chk("pend_limit", s_awready, 2'b10);
    @(posedge clk); #2;
    s_awvalid = 2'b01;
    m_bvalid = 1'b1;
    m_bid = 9'h0A0;
    s_bready = 2'b01;
    #1;
    chk("pend_hold",    s_awready, 2'b00);
    chk("pend_bvalid",  s_bvalid, 2'b01);
    @(posedge clk); #2;
    m_bvalid = 1'b0;
    #1;
    chk("pend_release", s_awready, 2'b01);
    chk("w_stall_m0",   s_wready, 2'b10);
    @(posedge clk); #2;

    s_awvalid = 2'b00;
    s_wvalid = 2'b11;
    s_wlast = 2'b11;
    #1;
    chk("drain_wvalid", m_wvalid, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    s_wvalid = 2'b00;

    // M1 has 1 pending: one good B, then a bad one with pend_cnt=0
    m_bvalid = 1'b1;
    m_bid = 9'h1B1;
    s_bready = 2'b10;
    #1;
    chk("pre_bad_err", err, 1'b0);
    @(posedge clk); #2;
    #1;
    chk("bad_b_route", s_bvalid, 2'b10);
    @(posedge clk); #2;
    m_bvalid = 1'b0;
    #1;
    chk("bad_b_err",   err, 1'b1);
    chk("bad_b_busy",  idle, 1'b0);
    m_bvalid = 1'b1;
    m_bid = 9'h0A0;
    s_bready = 2'b01;
    repeat (4) @(posedge clk);
    #2;
    m_bvalid = 1'b0;
    #1;
    chk("final_idle", idle, 1'b1);
    chk("err_sticky", err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
